toom_split_stream: RTL

TOOM_SPLIT_STREAM -- requirements
Module: toom_split_stream

---
 rtl/toom_split_stream.sv | 117 +++++++++++
 1 files changed

// File: rtl/toom_split_stream.sv
// Splits an operand pair into K limbs of CW bits and streams them one beat
// per handshake, least-significant first, sign-extending only the top limb.
module toom_split_stream #(
    parameter int W    = 1024,
    parameter int K    = 8,
    localparam int CW   = W / K,
    localparam int IDXW = ($clog2(K) > 1) ? $clog2(K) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    X,
    input  logic [W-1:0]    Y,
    input  logic            signed_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW:0]     a_chunk,
    output logic [CW:0]     b_chunk,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic [15:0]     pairs_done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    state_t          state_reg;
    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic            signed_reg;
    logic [IDXW-1:0] idx_reg;
    logic [15:0]     pairs_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;

    logic [CW-1:0]   x_limb [K];
    logic [CW-1:0]   y_limb [K];
    logic            at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            signed_reg    <= 1'b0;
            idx_reg       <= '0;
            pairs_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg         <= X;
                        y_reg         <= Y;
                        signed_reg    <= signed_mode;
                        idx_reg       <= '0;
                        state_reg     <= EMIT;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            // Back to IDLE only; a new pair waits one cycle.
                            state_reg     <= IDLE;
                            idx_reg       <= '0;
                            pairs_reg     <= pairs_reg + 16'd1;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_limb
        assign x_limb[gi] = x_reg[gi*CW +: CW];
        assign y_limb[gi] = y_reg[gi*CW +: CW];
    end

    assign at_last = (idx_reg == LAST_IDX);

    // Beat data is a pure decode of the held operands so it stays stable under backpressure.
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        out_idx  = '0;
        out_last = 1'b0;
        if (out_valid_reg) begin
            a_chunk  = {1'b0, x_limb[idx_reg]};
            b_chunk  = {1'b0, y_limb[idx_reg]};
            out_idx  = idx_reg;
            out_last = at_last;
            if (at_last && signed_reg) begin
                a_chunk[CW] = x_reg[W-1];
                b_chunk[CW] = y_reg[W-1];
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign pairs_done = pairs_reg;

endmodule
